// File: rtl/space_inv_pkg.sv
// Shared screen geometry, bus widths and the player fire-state encoding.
package space_inv_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PLAYER_W    = 31;
    localparam int NUM_MISSLES = 8;
    localparam int COL_W       = 12;
    localparam int SLOT_W      = $clog2(NUM_MISSLES);

    typedef enum logic [0:0] {
        FIRE_IDLE     = 1'b0,
        FIRE_COOLDOWN = 1'b1
    } fire_state_t;

    // One-hot mask selecting the missile slot whose toggle bit flips on a shot.
    function automatic logic [NUM_MISSLES-1:0] slot_mask(input logic [SLOT_W-1:0] slot);
        slot_mask = NUM_MISSLES'(1'b1) << slot;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level filter for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 315_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the pin, then accept a new level only after an unbroken run of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/player_input_ctrl.sv
// Board buttons to player command bus: column stepping and toggle-to-fire missile bits.
// Build option PLAYER_AUTOFIRE_EN: a held fire button keeps firing once per cooldown.
module player_input_ctrl
    import space_inv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 315_000,
    parameter int MOVE_DIV        = 250_000,
    parameter int MOVE_STEP       = 2,
    parameter int COL_MIN         = 0,
    parameter int COL_MAX         = 609,
    parameter int COL_RESET       = 305,
    parameter int FIRE_COOLDOWN   = 7_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_fire,
    output logic [COL_W-1:0]       btn_col,
    output logic [NUM_MISSLES-1:0] btn_missle_en,
    output logic                   fire_pulse,
    output logic [SLOT_W-1:0]      slot_ptr
);

    localparam int MOVE_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int COOL_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int COLX_W = COL_W + 1;

    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_DIV - 1);
    localparam logic [MOVE_W-1:0] MOVE_ONE  = MOVE_W'(1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(FIRE_COOLDOWN - 1);
    localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [COLX_W-1:0] STEP_X    = COLX_W'(MOVE_STEP);
    localparam logic [COLX_W-1:0] COL_MIN_X = COLX_W'(COL_MIN);
    localparam logic [COLX_W-1:0] COL_MAX_X = COLX_W'(COL_MAX);
    localparam logic [COL_W-1:0]  COL_MIN_V = COL_W'(COL_MIN);
    localparam logic [COL_W-1:0]  COL_MAX_V = COL_W'(COL_MAX);
    localparam logic [COL_W-1:0]  COL_RST_V = COL_W'(COL_RESET);

    logic                   left_lvl_s;
    logic                   right_lvl_s;
    logic                   fire_lvl_s;
    logic                   fire_trig_s;
    logic                   move_wrap_s;
    logic                   shot_s;
    fire_state_t            state_r;
    fire_state_t            state_nxt_s;
    logic [COOL_W-1:0]      cool_cnt_r;
    logic [COOL_W-1:0]      cool_nxt_s;
    logic [MOVE_W-1:0]      move_cnt_r;
    logic [COL_W-1:0]       col_r;
    logic [COL_W-1:0]       col_nxt_s;
    logic [COLX_W-1:0]      col_ext_s;
    logic [NUM_MISSLES-1:0] missle_en_r;
    logic [NUM_MISSLES-1:0] missle_nxt_s;
    logic                   fire_pulse_r;
    logic [SLOT_W-1:0]      slot_ptr_r;
    logic [SLOT_W-1:0]      slot_nxt_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_left),
        .level (left_lvl_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_right),
        .level (right_lvl_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_fire),
        .level (fire_lvl_s)
    );

`ifdef PLAYER_AUTOFIRE_EN
    assign fire_trig_s = fire_lvl_s;
`else
    logic fire_prev_r;

    // Previous debounced fire level, so only a fresh press can trigger a shot.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_prev_r <= 1'b0;
        end else begin
            fire_prev_r <= fire_lvl_s;
        end
    end

    assign fire_trig_s = fire_lvl_s & ~fire_prev_r;
`endif

    assign move_wrap_s = (move_cnt_r == MOVE_LAST);

    // Fire FSM next state; triggers arriving during cooldown are dropped.
    always_comb begin
        state_nxt_s  = state_r;
        cool_nxt_s   = cool_cnt_r;
        shot_s       = 1'b0;
        missle_nxt_s = missle_en_r;
        slot_nxt_s   = slot_ptr_r;
        case (state_r)
            space_inv_pkg::FIRE_IDLE: begin
                if (fire_trig_s) begin
                    shot_s       = 1'b1;
                    missle_nxt_s = missle_en_r ^ slot_mask(slot_ptr_r);
                    slot_nxt_s   = slot_ptr_r + SLOT_ONE;
                    cool_nxt_s   = COOL_LOAD;
                    state_nxt_s  = space_inv_pkg::FIRE_COOLDOWN;
                end else begin
                    state_nxt_s = space_inv_pkg::FIRE_IDLE;
                end
            end
            space_inv_pkg::FIRE_COOLDOWN: begin
                if (cool_cnt_r == '0) begin
                    state_nxt_s = space_inv_pkg::FIRE_IDLE;
                end else begin
                    cool_nxt_s = cool_cnt_r - COOL_ONE;
                end
            end
            default: begin
                state_nxt_s = space_inv_pkg::FIRE_IDLE;
                cool_nxt_s  = '0;
            end
        endcase
    end

    // Fire FSM state, cooldown timer and the registered missile command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= space_inv_pkg::FIRE_IDLE;
            cool_cnt_r   <= '0;
            missle_en_r  <= '0;
            fire_pulse_r <= 1'b0;
            slot_ptr_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            cool_cnt_r   <= cool_nxt_s;
            missle_en_r  <= missle_nxt_s;
            fire_pulse_r <= shot_s;
            slot_ptr_r   <= slot_nxt_s;
        end
    end

    // Column step with clamping done one bit wider so neither edge can wrap.
    always_comb begin
        col_ext_s = {1'b0, col_r};
        col_nxt_s = col_r;
        if (move_wrap_s && left_lvl_s && !right_lvl_s) begin
            if (col_ext_s < (COL_MIN_X + STEP_X)) begin
                col_nxt_s = COL_MIN_V;
            end else begin
                col_nxt_s = COL_W'(col_ext_s - STEP_X);
            end
        end else if (move_wrap_s && right_lvl_s && !left_lvl_s) begin
            if ((col_ext_s + STEP_X) > COL_MAX_X) begin
                col_nxt_s = COL_MAX_V;
            end else begin
                col_nxt_s = COL_W'(col_ext_s + STEP_X);
            end
        end else begin
            col_nxt_s = col_r;
        end
    end

    // Free-running movement divider and the registered column.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_cnt_r <= '0;
            col_r      <= COL_RST_V;
        end else begin
            move_cnt_r <= move_wrap_s ? '0 : (move_cnt_r + MOVE_ONE);
            col_r      <= col_nxt_s;
        end
    end

    assign btn_col       = col_r;
    assign btn_missle_en = missle_en_r;
    assign fire_pulse    = fire_pulse_r;
    assign slot_ptr      = slot_ptr_r;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Randomised scoreboard bench for player_input_ctrl against a behavioural model.
module tb_player_input_ctrl;

    localparam int DB   = 4;
    localparam int MD   = 8;
    localparam int MS   = 2;
    localparam int FC   = 20;
    localparam int CMIN = 0;
    localparam int CMAX = 609;
    localparam int CRST = 305;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_left  = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_fire  = 1'b0;
    logic [11:0] btn_col;
    logic [7:0]  btn_missle_en;
    logic        fire_pulse;
    logic [2:0]  slot_ptr;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .MOVE_DIV        (MD),
        .MOVE_STEP       (MS),
        .COL_MIN         (CMIN),
        .COL_MAX         (CMAX),
        .COL_RESET       (CRST),
        .FIRE_COOLDOWN   (FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_fire      (btn_fire),
        .btn_col       (btn_col),
        .btn_missle_en (btn_missle_en),
        .fire_pulse    (fire_pulse),
        .slot_ptr      (slot_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int col;} col_ev_t;
    typedef struct {int cyc; int en; int slot;} shot_ev_t;

    col_ev_t  colq[$];
    shot_ev_t shotq[$];

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int pulses     = 0;
    int mon_col    = CRST;
    int last_m_col = CRST;

    // Reference model state
    int m_col   = CRST;
    int m_en    = 0;
    int m_slot  = 0;
    int m_tick  = 0;
    int m_since = FC + 1;
    bit m_l     = 1'b0;
    bit m_r     = 1'b0;
    bit m_f     = 1'b0;
    bit m_fprev = 1'b0;
    bit [DB+1:0] h_l = '0;
    bit [DB+1:0] h_r = '0;
    bit [DB+1:0] h_f = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A debounced level adopts the opposite value once the last DB samples,
    // seen two clocks late through the synchroniser, all carry it.
    function automatic bit settle(input bit lvl, input bit [DB+1:0] h);
        bit [DB-1:0] win;
        win = h[DB+1:2];
        if (lvl) return (win == '0) ? 1'b0 : 1'b1;
        else     return (win == '1) ? 1'b1 : 1'b0;
    endfunction

    initial begin : model
        bit want;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_col = CRST; m_en = 0; m_slot = 0; m_tick = 0; m_since = FC + 1;
                m_l = 1'b0; m_r = 1'b0; m_f = 1'b0; m_fprev = 1'b0;
                h_l = '0; h_r = '0; h_f = '0;
            end else begin
                if (m_tick % MD == MD - 1) begin
                    if (m_l && !m_r)      m_col = (m_col - MS < CMIN) ? CMIN : m_col - MS;
                    else if (m_r && !m_l) m_col = (m_col + MS > CMAX) ? CMAX : m_col + MS;
                end
                m_tick++;
                m_since++;
`ifdef PLAYER_AUTOFIRE_EN
                want = m_f;
`else
                want = m_f && !m_fprev;
`endif
                if (want && m_since > FC) begin
                    m_en    = m_en ^ (1 << m_slot);
                    m_slot  = (m_slot + 1) % 8;
                    m_since = 0;
                    shotq.push_back('{cyc, m_en, m_slot});
                end
                m_fprev = m_f;
                h_l = {h_l[DB:0], btn_left};
                h_r = {h_r[DB:0], btn_right};
                h_f = {h_f[DB:0], btn_fire};
                m_l = settle(m_l, h_l);
                m_r = settle(m_r, h_r);
                m_f = settle(m_f, h_f);
            end
            if (m_col != last_m_col) begin
                colq.push_back('{cyc, m_col});
                last_m_col = m_col;
            end
        end
    end

    initial begin : monitor
        col_ev_t  ce;
        shot_ev_t se;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (int'(btn_col) != mon_col) begin
                mon_col = int'(btn_col);
                chk("col_event_queued", int'(colq.size() > 0), 1);
                if (colq.size() > 0) begin
                    ce = colq.pop_front();
                    chk("col_value", mon_col, ce.col);
                    chk("col_cycle", cyc, ce.cyc);
                end
            end
            if (fire_pulse === 1'b1) begin
                pulses++;
                chk("shot_queued", int'(shotq.size() > 0), 1);
                if (shotq.size() > 0) begin
                    se = shotq.pop_front();
                    chk("shot_cycle", cyc, se.cyc);
                    chk("shot_missle_en", int'(btn_missle_en), se.en);
                    chk("shot_slot_ptr", int'(slot_ptr), se.slot);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        btn_fire = 1'b1;
        tick(hold);
        btn_fire = 1'b0;
        tick(gap);
    endtask

    initial begin : stim
        int p0;
        tick(3);
        chk("reset_btn_col", int'(btn_col), CRST);
        chk("reset_missle_en", int'(btn_missle_en), 0);
        chk("reset_slot_ptr", int'(slot_ptr), 0);
        chk("reset_fire_pulse", int'(fire_pulse), 0);
        rst = 1'b0;

        btn_right = 1'b1; tick(1300);
        chk("right_clamp", int'(btn_col), CMAX);
        btn_right = 1'b0; tick(20);
        btn_left = 1'b1; tick(2600);
        chk("left_clamp", int'(btn_col), CMIN);
        btn_left = 1'b0; tick(20);

        p0 = pulses;
        btn_fire = 1'b1; tick(2); btn_fire = 1'b0; tick(2);
        btn_fire = 1'b1; tick(12); btn_fire = 1'b0; tick(5);
        chk("bounce_single_pulse", pulses - p0, 1);
        chk("first_shot_en", int'(btn_missle_en), 1);
        chk("first_shot_slot", int'(slot_ptr), 1);
        press(4, 10);
        chk("cooldown_drop_en", int'(btn_missle_en), 1);
        press(8, 30);
        chk("second_shot_en", int'(btn_missle_en), 3);

        rst = 1'b1; tick(2); rst = 1'b0;
        for (int i = 0; i < 9; i++) press(8, 30);
        chk("nine_shots_en", int'(btn_missle_en), 254);
        chk("nine_shots_slot", int'(slot_ptr), 1);

        btn_fire = 1'b1; tick(8);
        btn_fire = 1'b0; btn_right = 1'b1; tick(3);
        rst = 1'b1; tick(1);
        chk("midrst_btn_col", int'(btn_col), CRST);
        chk("midrst_missle_en", int'(btn_missle_en), 0);
        chk("midrst_slot_ptr", int'(slot_ptr), 0);
        chk("midrst_fire_pulse", int'(fire_pulse), 0);
        rst = 1'b0;
        btn_fire = 1'b1; tick(8);
        chk("post_rst_shot_en", int'(btn_missle_en), 1);
        btn_fire = 1'b0; btn_right = 1'b0; tick(20);

`ifdef PLAYER_AUTOFIRE_EN
        p0 = pulses;
        btn_fire = 1'b1; tick(100);
        btn_fire = 1'b0; tick(10);
        chk("autofire_pulses", pulses - p0, 5);
`endif

        for (int s = 0; s < 150; s++) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_fire  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            tick(int'($urandom_range(1, 40)));
        end
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
        tick(40);

        chk("col_events_drained", colq.size(), 0);
        chk("shot_events_drained", shotq.size(), 0);
        chk("final_missle_en", int'(btn_missle_en), m_en);
        chk("final_slot_ptr", int'(slot_ptr), m_slot);
        chk("final_btn_col", int'(btn_col), m_col);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
